// File: rtl/div_sequencer_if.sv
// Issue/writeback handshake plus launch/completion bus to the SRT divider.
// The sequencer takes the slave side; the issue stage and divider model the master side.
interface div_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_rs1;
  logic [XLEN-1:0]  req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;

  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  logic             div_start;
  logic [XLEN-1:0]  div_dividend;
  logic [XLEN-1:0]  div_divisor;
  logic             div_is_signed;
  logic [XLEN-1:0]  div_quotient;
  logic [XLEN-1:0]  div_remainder;
  logic             div_done;
  logic             div_by_zero;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_tag, flush, resp_ready,
           div_quotient, div_remainder, div_done, div_by_zero,
    input  req_ready, resp_valid, resp_data, resp_tag, busy,
           div_start, div_dividend, div_divisor, div_is_signed
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_tag, flush, resp_ready,
           div_quotient, div_remainder, div_done, div_by_zero,
    output req_ready, resp_valid, resp_data, resp_tag, busy,
           div_start, div_dividend, div_divisor, div_is_signed
  );
endinterface

// File: rtl/div_sequencer.sv
// Sequences one integer divide/remainder op through an external SRT divider,
// resolving divide-by-zero and signed overflow locally without launching it.
//
// state  | meaning
// IDLE   | ready for a new op
// LAUNCH | div_start pulse to the divider
// WAIT   | divider running, result pending
// DRAIN  | flushed op still running in the divider; result discarded
// RESP   | result held on resp_* until writeback takes it
module div_sequencer #(
  parameter int XLEN  = 32,  // core datapath width
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  div_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    DRAIN  = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t           r_state;
  logic [XLEN-1:0]  r_rs1;
  logic [XLEN-1:0]  r_rs2;
  logic [TAG_W-1:0] r_tag;
  logic             r_is_signed;
  logic             r_want_rem;
  logic [XLEN-1:0]  r_result;
  logic             r_resp_valid;
  logic             r_div_start;

  logic w_req_ready;
  logic w_accept;
  logic w_signed_in;
  logic w_want_rem_in;
  logic w_div_zero;
  logic w_overflow;
  logic w_unused;

  assign w_req_ready   = (r_state == IDLE);
  assign w_accept      = bus.req_valid & w_req_ready & ~bus.flush;
  assign w_signed_in   = ~bus.req_op[0];
  assign w_want_rem_in = bus.req_op[1];
  assign w_div_zero    = (bus.req_rs2 == '0);
  assign w_overflow    = w_signed_in & (bus.req_rs1 == MIN_NEG) & (bus.req_rs2 == ALL_ONES);

  // Divide-by-zero never reaches the divider, so its own flag carries no information.
  assign w_unused = bus.div_by_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_tag        <= '0;
      r_is_signed  <= 1'b0;
      r_want_rem   <= 1'b0;
      r_result     <= '0;
      r_resp_valid <= 1'b0;
      r_div_start  <= 1'b0;
    end else begin
      r_div_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rs1       <= bus.req_rs1;
            r_rs2       <= bus.req_rs2;
            r_tag       <= bus.req_tag;
            r_is_signed <= w_signed_in;
            r_want_rem  <= w_want_rem_in;
            if (w_div_zero) begin
              r_result     <= w_want_rem_in ? bus.req_rs1 : ALL_ONES;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else if (w_overflow) begin
              r_result     <= w_want_rem_in ? '0 : MIN_NEG;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_div_start <= 1'b1;
              r_state     <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          r_state <= bus.flush ? DRAIN : WAIT;
        end
        WAIT: begin
          // A flush coinciding with completion has nothing left to drain.
          if (bus.flush) begin
            r_state <= bus.div_done ? IDLE : DRAIN;
          end else if (bus.div_done) begin
            r_result     <= r_want_rem ? bus.div_remainder : bus.div_quotient;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        DRAIN: begin
          if (bus.div_done) begin
            r_state <= IDLE;
          end
        end
        RESP: begin
          if (bus.flush || bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.busy          = ~w_req_ready;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_data     = r_result;
  assign bus.resp_tag      = r_tag;
  assign bus.div_start     = r_div_start;
  assign bus.div_dividend  = r_rs1;
  assign bus.div_divisor   = r_rs2;
  assign bus.div_is_signed = r_is_signed;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: behavioural SRT divider stub, scoreboard of expected
// results, directed and randomised op streams.
module tb_div_sequencer;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } exp_t;

  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    bit              fast;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_sequencer_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  div_sequencer #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc++;

  // Divider stub: result div_lat negedges after seeing div_start.
  int              div_lat   = 3;
  int              start_cnt = 0;
  int              done_cnt  = 0;
  int              done_cyc  = -1;
  int              cnt       = 0;
  int              stable_err = 0;
  bit              spur_req  = 1'b0;
  logic [XLEN-1:0] cap_a, cap_b;
  logic            cap_s;

  always @(negedge clk) begin
    if (rst) begin
      cnt               = 0;
      bus.div_done      = 1'b0;
      bus.div_quotient  = '0;
      bus.div_remainder = '0;
    end else begin
      bus.div_done = 1'b0;
      if (spur_req) begin
        bus.div_done      = 1'b1;
        bus.div_quotient  = 32'hDEAD_BEEF;
        bus.div_remainder = 32'hDEAD_BEEF;
        spur_req          = 1'b0;
      end
      if (cnt > 0) begin
        if (bus.div_dividend !== cap_a || bus.div_divisor !== cap_b || bus.div_is_signed !== cap_s)
          stable_err++;
        cnt--;
        if (cnt == 0) begin
          if (cap_s) begin
            bus.div_quotient  = $signed(cap_a) / $signed(cap_b);
            bus.div_remainder = $signed(cap_a) % $signed(cap_b);
          end else begin
            bus.div_quotient  = cap_a / cap_b;
            bus.div_remainder = cap_a % cap_b;
          end
          bus.div_done = 1'b1;
          done_cnt++;
          done_cyc = cyc;
        end
      end
      if (bus.div_start === 1'b1) begin
        start_cnt++;
        cap_a = bus.div_dividend;
        cap_b = bus.div_divisor;
        cap_s = bus.div_is_signed;
        cnt   = div_lat;
      end
    end
  end

  function automatic logic [XLEN-1:0] ref_div(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic s, r;
    s = ~op[0];
    r = op[1];
    if (b == '0) return r ? a : '1;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? '0 : 32'h8000_0000;
    if (s) return r ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    return r ? a % b : a / b;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tag, input bit push, input logic [XLEN-1:0] exp);
    if (push) sb_q.push_back('{tag: tag, data: exp});
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_tag   = tag;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output bit to);
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    to = (bus.resp_valid !== 1'b1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp,
                        output logic [XLEN-1:0] got_d, output logic [TAG_W-1:0] got_t, output exp_t want,
                        output int lat, output int dlat, output int starts, output bit to);
    int s0;
    s0 = start_cnt;
    issue(op, a, b, tag, 1'b1, exp);
    wait_resp(lat, to);
    dlat   = cyc - done_cyc;
    got_d  = bus.resp_data;
    got_t  = bus.resp_tag;
    want   = sb_q.pop_front();
    starts = start_cnt - s0;
    if (bus.resp_ready === 1'b1 && !to) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b expected 0", bus.resp_valid); end
    n_checks++; if (bus.div_start !== 1'b0) begin n_fail++; $display("FAIL rst_div_start: got %b expected 0", bus.div_start); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.resp_data !== 32'h0) begin n_fail++; $display("FAIL rst_resp_data: got %h expected 0", bus.resp_data); end
    n_checks++; if (bus.resp_tag !== 5'h0) begin n_fail++; $display("FAIL rst_resp_tag: got %h expected 0", bus.resp_tag); end
    n_checks++; if (bus.div_dividend !== 32'h0 || bus.div_divisor !== 32'h0 || bus.div_is_signed !== 1'b0) begin
      n_fail++; $display("FAIL rst_div_operands: got %h %h %b expected 0 0 0", bus.div_dividend, bus.div_divisor, bus.div_is_signed); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_divu();
    logic [XLEN-1:0] d; logic [TAG_W-1:0] t; exp_t w; int lat, dlat, st; bit to;
    div_lat = 4;
    stable_err = 0;
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, d, t, w, lat, dlat, st, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL divu_timeout: got no resp_valid expected resp_valid"); end
    n_checks++; if (d !== w.data) begin n_fail++; $display("FAIL divu_data: got %h expected %h", d, w.data); end
    n_checks++; if (t !== w.tag) begin n_fail++; $display("FAIL divu_tag: got %h expected %h", t, w.tag); end
    n_checks++; if (st !== 1) begin n_fail++; $display("FAIL divu_starts: got %0d expected 1", st); end
    n_checks++; if (dlat !== 1) begin n_fail++; $display("FAIL divu_latency: got %0d expected 1", dlat); end
    n_checks++; if (cap_a !== 32'd100 || cap_b !== 32'd7 || cap_s !== 1'b0) begin
      n_fail++; $display("FAIL divu_operands: got %h %h %b expected 64 7 0", cap_a, cap_b, cap_s); end
    n_checks++; if (stable_err !== 0) begin n_fail++; $display("FAIL divu_operand_stable: got %0d errors expected 0", stable_err); end
    n_checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL divu_release: got valid=%b ready=%b expected 0 1", bus.resp_valid, bus.req_ready); end
  endtask

  task automatic test_vectors(input string name, input vec_t v[]);
    logic [XLEN-1:0] d; logic [TAG_W-1:0] t; exp_t w; int lat, dlat, st; bit to;
    foreach (v[i]) begin
      div_lat = 2 + i;
      run_op(v[i].op, v[i].a, v[i].b, TAG_W'(i + 10), v[i].exp, d, t, w, lat, dlat, st, to);
      n_checks++; if (to || d !== w.data || t !== w.tag) begin
        n_fail++; $display("FAIL %s_%0d_result: got %h tag %h expected %h tag %h", name, i, d, t, w.data, w.tag); end
      n_checks++; if (st !== (v[i].fast ? 0 : 1)) begin
        n_fail++; $display("FAIL %s_%0d_starts: got %0d expected %0d", name, i, st, v[i].fast ? 0 : 1); end
      n_checks++; if ((v[i].fast && lat !== 0) || (!v[i].fast && dlat !== 1)) begin
        n_fail++; $display("FAIL %s_%0d_latency: got %0d/%0d expected %0d", name, i, lat, dlat, v[i].fast ? 0 : 1); end
    end
  endtask

  task automatic test_slow_path();
    vec_t v[] = new[4];
    v[0] = '{OP_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0};
    v[1] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0};
    v[2] = '{OP_REMU, 32'd100,       32'd7,        32'd2,         1'b0};
    v[3] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b0};
    test_vectors("slow", v);
  endtask

  task automatic test_div_zero();
    vec_t v[] = new[4];
    v[0] = '{OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1};
    v[1] = '{OP_REMU, 32'd5, 32'd0, 32'd5,         1'b1};
    v[2] = '{OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1};
    v[3] = '{OP_REM,  32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 1'b1};
    test_vectors("divzero", v);
  endtask

  task automatic test_overflow();
    vec_t v[] = new[2];
    v[0] = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    v[1] = '{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1};
    test_vectors("overflow", v);
  endtask

  task automatic test_flush_drain();
    logic [XLEN-1:0] d; logic [TAG_W-1:0] t; exp_t w; int lat, dlat, st; bit to;
    int delays[2] = '{0, 3};
    foreach (delays[k]) begin
      int s0, d0, bad, n;
      div_lat = 10;
      s0 = start_cnt;
      d0 = done_cnt;
      issue(OP_DIVU, 32'd50, 32'd5, 5'd7, 1'b0, '0);
      repeat (delays[k]) begin @(posedge clk); #1; end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bad = 0;
      n = 0;
      while (done_cnt == d0 && n < 100) begin
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) bad++;
        @(posedge clk); #1;
        n++;
      end
      n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL flush%0d_starts: got %0d expected 1", k, start_cnt - s0); end
      n_checks++; if (bad !== 0 || done_cnt == d0) begin
        n_fail++; $display("FAIL flush%0d_drain: got %0d bad cycles done=%0d expected 0 bad done=1", k, bad, done_cnt - d0); end
      n_checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush%0d_idle: got ready=%b valid=%b expected 1 0", k, bus.req_ready, bus.resp_valid); end
    end
    div_lat = 3;
    run_op(OP_DIVU, 32'd9, 32'd3, 5'd8, 32'd3, d, t, w, lat, dlat, st, to);
    n_checks++; if (to || d !== w.data || t !== w.tag) begin
      n_fail++; $display("FAIL flush_next_op: got %h tag %h expected %h tag %h", d, t, w.data, w.tag); end
  endtask

  task automatic test_flush_idle_resp();
    int s0;
    s0 = start_cnt;
    bus.req_op = OP_DIVU; bus.req_rs1 = 32'd9; bus.req_rs2 = 32'd3; bus.req_tag = 5'd2;
    bus.req_valid = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0 || start_cnt !== s0 || bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_accept: got busy=%b starts=%0d expected 0 0", bus.busy, start_cnt - s0); end
    bus.resp_ready = 1'b0;
    issue(OP_DIV, 32'd1, 32'd0, 5'd3, 1'b0, '0);
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_resp_pre: got %b expected 1", bus.resp_valid); end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_resp_drop: got valid=%b ready=%b expected 0 1", bus.resp_valid, bus.req_ready); end
    bus.resp_ready = 1'b1;
  endtask

  task automatic test_spurious_done();
    spur_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL spur_idle: got busy=%b valid=%b expected 0 0", bus.busy, bus.resp_valid); end
    bus.resp_ready = 1'b0;
    issue(OP_DIVU, 32'd7, 32'd0, 5'd4, 1'b0, '0);
    spur_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL spur_resp: got valid=%b data=%h expected 1 ffffffff", bus.resp_valid, bus.resp_data); end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_resp_hold();
    logic [XLEN-1:0] d; logic [TAG_W-1:0] t; exp_t w; int lat, dlat, st; bit to;
    div_lat = 3;
    bus.resp_ready = 1'b0;
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, d, t, w, lat, dlat, st, to);
    n_checks++; if (to || d !== w.data || t !== w.tag) begin
      n_fail++; $display("FAIL hold_first: got %h tag %h expected %h tag %h", d, t, w.data, w.tag); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd14 || bus.resp_tag !== 5'd9) begin
        n_fail++; $display("FAIL hold_cycle%0d: got %b %h %h expected 1 0000000e 09", c, bus.resp_valid, bus.resp_data, bus.resp_tag); end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b expected 0", bus.resp_valid); end
  endtask

  task automatic test_reset_mid_wait();
    int d0;
    div_lat = 20;
    d0 = done_cnt;
    issue(OP_DIV, 32'd1000, 32'd3, 5'd17, 1'b0, '0);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.div_start !== 1'b0 || bus.resp_data !== 32'h0 ||
                    bus.resp_tag !== 5'h0 || bus.div_dividend !== 32'h0 || bus.div_divisor !== 32'h0 || bus.div_is_signed !== 1'b0) begin
      n_fail++; $display("FAIL midwait_rst: got busy=%b valid=%b start=%b data=%h tag=%h dvd=%h dvs=%h s=%b expected all 0",
                         bus.busy, bus.resp_valid, bus.div_start, bus.resp_data, bus.resp_tag, bus.div_dividend, bus.div_divisor, bus.div_is_signed); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || done_cnt !== d0) begin
      n_fail++; $display("FAIL midwait_after: got ready=%b busy=%b expected 1 0", bus.req_ready, bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] d; logic [TAG_W-1:0] t; exp_t w; int lat, dlat, st; bit to;
    for (int i = 0; i < 16; i++) begin
      logic [1:0] op; logic [XLEN-1:0] a, b;
      int mode;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      mode = $urandom_range(0, 5);
      if (mode == 0) b = '0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) b = 32'($urandom_range(1, 20));
      div_lat = $urandom_range(1, 5);
      run_op(op, a, b, TAG_W'(i), ref_div(op, a, b), d, t, w, lat, dlat, st, to);
      n_checks++; if (to || d !== w.data || t !== w.tag) begin
        n_fail++; $display("FAIL b2b_%0d: op %b %h/%h got %h tag %h expected %h tag %h", i, op, a, b, d, t, w.data, w.tag); end
    end
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_op      = 2'b00;
    bus.req_rs1     = '0;
    bus.req_rs2     = '0;
    bus.req_tag     = '0;
    bus.flush       = 1'b0;
    bus.resp_ready  = 1'b1;
    bus.div_by_zero = 1'b0;
    test_reset();
    test_divu();
    test_slow_path();
    test_div_zero();
    test_overflow();
    test_flush_drain();
    test_flush_idle_resp();
    test_spurious_done();
    test_resp_hold();
    test_back_to_back();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter XLEN, default core_config_pkg::XLEN (32), operand/result width.
REQ-002 Parameter TAG_W, default 5, destination tag width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  issue offers a divide op.
REQ-006 req_ready  out  1  block accepts op this cycle.
REQ-007 req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 req_rs1 / req_rs2  in  XLEN each  dividend / divisor.
REQ-009 req_tag  in  TAG_W  destination tag.
REQ-010 flush  in  1  discard in-flight op.
REQ-011 resp_valid  out  1  result available.
REQ-012 resp_ready  in  1  writeback accepts result.
REQ-013 resp_data  out  XLEN  result; resp_tag  out  TAG_W  tag of result.
REQ-014 busy  out  1  state != IDLE.
REQ-015 div_start  out  1  one-cycle launch pulse to the SRT divider.
REQ-016 div_dividend / div_divisor  out  XLEN each; div_is_signed  out  1.
REQ-017 div_quotient / div_remainder  in  XLEN each; div_done  in  1; div_by_zero  in  1.

Function
REQ-018 States: IDLE, LAUNCH, WAIT, DRAIN, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready & !flush.
REQ-020 On accept: register op, rs1, rs2, tag; is_signed = ~op[0]; want_rem = op[1].
REQ-021 Fast path, divisor==0: result = all-ones (DIV/DIVU) or rs1 (REM/REMU); go RESP next cycle; no div_start.
REQ-022 Fast path, signed overflow (signed op, rs1==0x8000_0000, rs2==0xFFFF_FFFF): result = 0x8000_0000 (DIV) or 0 (REM); go RESP next cycle; no div_start.
REQ-023 Otherwise go LAUNCH; LAUNCH asserts div_start for exactly one cycle, then WAIT.
REQ-024 div_dividend, div_divisor, div_is_signed SHALL be driven from the registered operands and held stable from LAUNCH until div_done is sampled.
REQ-025 WAIT: on div_done, capture div_remainder if want_rem else div_quotient; go RESP. div_by_zero high with div_done is ignored (already handled by REQ-021).
REQ-026 Latency: fast path resp_valid 1 cycle after accept; slow path resp_valid 1 cycle after div_done.
REQ-027 RESP: resp_valid=1, resp_data/resp_tag stable until resp_valid & resp_ready, then IDLE.
REQ-028 flush in LAUNCH or WAIT: go DRAIN (div_start still issued if in LAUNCH); DRAIN waits for div_done, discards result, then IDLE; resp_valid never asserted.
REQ-029 flush in RESP: drop result, IDLE next cycle, resp_valid low from that cycle.
REQ-030 flush with req_valid in IDLE: no accept.
REQ-031 div_done seen outside WAIT/DRAIN is ignored.
REQ-032 No new op accepted until return to IDLE (one op in flight max).

Reset
REQ-033 rst asynchronously forces IDLE; resp_valid=0, div_start=0, busy=0, resp_data=0, resp_tag=0, div_dividend=0, div_divisor=0, div_is_signed=0, req_ready=1 once rst deasserted.
REQ-034 rst mid-WAIT abandons op; caller resets the SRT divider in the same reset domain.

Verification
REQ-035 DIVU 100/7, resp_ready=1 -> one div_start pulse, resp_data=14, resp_tag echoed, resp_valid 1 cycle after div_done.
REQ-036 REM 0xFFFF_FFF9 (-7) % 2 -> resp_data=0xFFFF_FFFF (-1).
REQ-037 DIV 5/0 -> no div_start, resp_data=0xFFFF_FFFF next cycle; REMU 5/0 -> resp_data=5.
REQ-038 DIV 0x8000_0000/0xFFFF_FFFF -> resp_data=0x8000_0000, no div_start; REM same operands -> 0.
REQ-039 flush 3 cycles after LAUNCH -> DRAIN, req_ready low until div_done, no resp_valid; next DIVU 9/3 -> 3.
REQ-040 resp_ready low 10 cycles in RESP -> resp_valid, resp_data, resp_tag held constant; assert rst mid-WAIT -> all outputs at reset values immediately.
